keypad_scan_entry: RTL and testbench
====================================

Name: keypad_scan_entry

Overview:
- Input-side counterpart to the two-digit multiplexed 7-segment display driver.
- Scans a 4x4 matrix keypad row by row, synchronises and debounces the column returns, and decodes key presses.
- Accumulates decimal digits into a two-digit entry and produces a committed 7-bit binary value (0-99) that feeds the display driver's binary input.

Parameters:
- SCAN_DIV, 50000: clk cycles per row dwell; the column sample is taken on the last cycle of each dwell.
- DEBOUNCE_SCANS, 4: number of consecutive matching samples required to accept a press and, separately, a release.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- col_in  in  4  keypad column returns, active-low (external pull-ups); asynchronous to clk
- row_out  out  4  row drive, active-low one-hot
- key_code  out  4  code of the last accepted key
- key_strobe  out  1  one-cycle pulse when a key is accepted
- value_out  out  7  last committed entry, binary 0-99
- value_valid  out  1  one-cycle pulse when value_out is updated

Behaviour:
- Reset values: row_out=4'b1110 (row 0); key_code=0; key_strobe=0; value_out=0; value_valid=0; tens=units=0; state=SCAN; divider=0; debounce counter=0.
- Reset mid-operation returns to SCAN. A key still held after reset is detected and accepted again as a new press.
- col_in passes through a 2-flop synchroniser. All decisions use the synchronised value (col_s), so there are 2 cycles of input latency.
- Divider counts 0..SCAN_DIV-1 and wraps. tick=1 when the divider equals SCAN_DIV-1. The divider free-runs in all states.
- Key map, (row,col) -> code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Column c corresponds to col_in[c]; row r corresponds to row_out[r]=0.
- State SCAN, on tick:
  - If col_s has exactly one low bit: latch the column pattern, debounce counter=1, go to DEBOUNCE. row_out is held.
  - Otherwise (no key, or several keys low in this row): rotate row_out to the next row (r3 wraps to r0), stay in SCAN.
- State DEBOUNCE, on tick:
  - If col_s equals the latched pattern: increment the counter.
  - When the counter reaches DEBOUNCE_SCANS: go to PRESSED, register key_code, and assert key_strobe for exactly 1 cycle.
  - On mismatch: return to SCAN and rotate the row. No strobe.
- State PRESSED, row held, on tick:
  - If col_s==4'b1111: increment the release counter; otherwise clear it.
  - When the release counter reaches DEBOUNCE_SCANS: go to SCAN and rotate the row.
  - A held key therefore produces exactly one strobe. Other keys pressed while in PRESSED are ignored.
- Entry logic acts on the cycle key_strobe is high:
  - Digit 0-9: tens<=units, units<=digit (shift-in; older digits drop out).
  - E (*): tens<=0, units<=0. value_out is unchanged and no value_valid pulse.
  - F (#): value_out<=tens*10+units, and value_valid pulses 1 cycle later, coincident with the new value_out.
  - A-D: strobed on key_code only; the entry is unchanged.
- Arithmetic: tens and units are 4 bits and always 0-9. The product is computed as (tens<<3)+(tens<<1)+units and fits in 7 bits (max 99). No saturation is required.
- There is no simultaneous-key ambiguity across rows, because only one row is driven at a time.

Decomposition:
- Shared package:
  - Key code constants: KEY_STAR=4'hE, KEY_HASH=4'hF.
  - Scan state encoding: SCAN, DEBOUNCE, PRESSED.
  - The 4x4 key map function (row,col -> code).
- One natural sub-module, keypad_matrix_scanner. It contains the synchroniser, divider, FSM, row drive, key_code and key_strobe.
- The top level adds the digit-entry and commit logic.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, clean presses held for 40 scans, released for 40 scans):
- Press 4, 2, # -> three key_strobe pulses with key_code 4, 2, F; value_out=42; single-cycle value_valid.
- Press 1, 2, 3, # -> value_out=23 (the 1 is shifted out); then press *, # -> value_out=0 with a value_valid pulse.
- Assert key 5 (row1, col1) low for 2 samples, then release -> no key_strobe, state returns to SCAN, and row_out keeps rotating through 1110, 1101, 1011, 0111.
- Hold key 9 for 200 scans -> exactly one key_strobe (key_code=9); after release, the next press of 9 strobes again.
- Hold keys 7 and 8 together (same row) -> no strobe while both are held; releasing 8 leaves 7 held -> one strobe with key_code=7.
- Assert rst while in PRESSED with key 3 held -> all outputs at reset values the next cycle; key 3 is re-accepted after DEBOUNCE_SCANS samples; value_out stays 0 until #.

Source files
------------

// File: rtl/keypad_scan_entry_pkg.sv
// Shared definitions for the keypad scanner and digit-entry logic:
// key codes, scan FSM encoding and the 4x4 key map.
package keypad_scan_entry_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } scan_state_e;

    function automatic logic single_low(input logic [3:0] v);
        return v inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    endfunction

    // Index of the single low bit; only meaningful when single_low(v) holds.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        case (v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: return 4'h1;
            4'h1: return 4'h2;
            4'h2: return 4'h3;
            4'h3: return 4'hA;
            4'h4: return 4'h4;
            4'h5: return 4'h5;
            4'h6: return 4'h6;
            4'h7: return 4'hB;
            4'h8: return 4'h7;
            4'h9: return 4'h8;
            4'hA: return 4'h9;
            4'hB: return 4'hC;
            4'hC: return KEY_STAR;
            4'hD: return 4'h0;
            4'hE: return KEY_HASH;
            default: return 4'hD;
        endcase
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner.sv
// Row scanner for a 4x4 active-low keypad: synchroniser, dwell divider,
// press/release debounce FSM and a one-cycle strobe per accepted key.
module keypad_matrix_scanner
    import keypad_scan_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] col_i,
    output logic [3:0] row_o,
    output logic [3:0] key_code_o,
    output logic       key_strobe_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]       sync1_q, col_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    scan_state_e      state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             strobe_q, strobe_d;
    logic             tick;
    logic             cnt_done;
    logic [3:0]       row_next;

    assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
    assign cnt_done = ((cnt_q + CNT_W'(1)) == CNT_W'(DEBOUNCE_SCANS));
    assign row_next = {row_q[2:0], row_q[3]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 4'b1111;
            col_s_q  <= 4'b1111;
            div_q    <= '0;
            state_q  <= SCAN;
            row_q    <= 4'b1110;
            pat_q    <= 4'b1111;
            cnt_q    <= '0;
            code_q   <= 4'h0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= col_i;
            col_s_q  <= sync1_q;
            div_q    <= div_d;
            state_q  <= state_d;
            row_q    <= row_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        state_d  = state_q;
        row_d    = row_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        strobe_d = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    // Several lows in one row are ambiguous: skip the row.
                    if (single_low(col_s_q)) begin
                        pat_d   = col_s_q;
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_next;
                    end
                end
                DEBOUNCE: begin
                    if (col_s_q == pat_q) begin
                        if (cnt_done) begin
                            state_d  = PRESSED;
                            code_d   = key_map(low_idx(row_q), low_idx(pat_q));
                            strobe_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = SCAN;
                        row_d   = row_next;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (col_s_q == 4'b1111) begin
                        if (cnt_done) begin
                            state_d = SCAN;
                            row_d   = row_next;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign row_o        = row_q;
    assign key_code_o   = code_q;
    assign key_strobe_o = strobe_q;

endmodule

// File: rtl/keypad_scan_entry.sv
// Keypad entry top: scanned key presses shift decimal digits into a
// two-digit entry; '*' clears it and '#' commits it as a 0-99 binary value.
module keypad_scan_entry
    import keypad_scan_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic [6:0] value_out,
    output logic       value_valid
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic [6:0] value_q, value_d;
    logic       vv_q, vv_d;

    keypad_matrix_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scan (
        .clk_i        (clk),
        .rst_i        (rst),
        .col_i        (col_in),
        .row_o        (row_out),
        .key_code_o   (key_code),
        .key_strobe_o (key_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            value_q <= 7'd0;
            vv_q    <= 1'b0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
            value_q <= value_d;
            vv_q    <= vv_d;
        end
    end

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        value_d = value_q;
        vv_d    = 1'b0;
        if (key_strobe) begin
            if (key_code < 4'd10) begin
                tens_d  = units_q;
                units_d = key_code;
            end else if (key_code == KEY_STAR) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
            end else if (key_code == KEY_HASH) begin
                // tens*10 as shift-add; max 99 fits in 7 bits.
                value_d = {tens_q, 3'b000} + {2'b00, tens_q, 1'b0} + {3'b000, units_q};
                vv_d    = 1'b1;
            end
        end
    end

    assign value_out   = value_q;
    assign value_valid = vv_q;

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Scoreboard bench for keypad_scan_entry: a keypad model drives col_in from
// row_out; expected key codes and committed values are queued and popped.
module tb_keypad_scan_entry;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_strobe;
    logic [6:0] value_out;
    logic       value_valid;

    logic [15:0] keys = '0;
    logic [3:0]  kq[$];
    int          vq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_tens  = 0;
    int          m_units = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_hash   = 1'b0;
    logic        prev_vv     = 1'b0;

    keypad_scan_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk         (clk),
        .rst         (rst),
        .col_in      (col_in),
        .row_out     (row_out),
        .key_code    (key_code),
        .key_strobe  (key_strobe),
        .value_out   (value_out),
        .value_valid (value_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
    end

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] code);
        for (int i = 0; i < 16; i++)
            if (KMAP[i] == code) return i;
        return 0;
    endfunction

    task automatic model_key(input logic [3:0] code);
        kq.push_back(code);
        if (code < 4'd10) begin
            m_tens  = m_units;
            m_units = int'(code);
        end else if (code == 4'hE) begin
            m_tens  = 0;
            m_units = 0;
        end else if (code == 4'hF) begin
            vq.push_back(m_tens * 10 + m_units);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SD) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code);
        model_key(code);
        keys[idx_of(code)] = 1'b1;
        wait_scans(40);
        keys[idx_of(code)] = 1'b0;
        wait_scans(40);
        check("key_drain", kq.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_row", row_out, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_strobe", key_strobe, 0);
        check("rst_value", value_out, 0);
        check("rst_vv", value_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (key_strobe) begin
                check("strobe_width", prev_strobe, 0);
                if (kq.size() == 0) check("strobe_unexp", key_code, 16);
                else check("key_code", key_code, kq.pop_front());
            end
            if (value_valid) begin
                check("vv_after_hash", prev_hash, 1);
                check("vv_width", prev_vv, 0);
                if (vq.size() == 0) check("vv_unexp", value_out, 128);
                else check("value_out", value_out, vq.pop_front());
            end
        end
        prev_strobe = key_strobe;
        prev_hash   = key_strobe && (key_code == 4'hF);
        prev_vv     = value_valid;
    end

    initial begin
        logic [3:0] prev_row;
        int         cnt;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        press(4'h4); press(4'h2); press(4'hF);
        press(4'h1); press(4'h2); press(4'h3); press(4'hF);
        press(4'hE); press(4'hF);

        // Key 5 visible for exactly two samples: aligned to the row1 dwell start.
        cnt = 0;
        while (row_out == 4'b1101 && cnt < 100) begin @(negedge clk); cnt++; end
        cnt = 0;
        while (row_out != 4'b1101 && cnt < 100) begin @(negedge clk); cnt++; end
        check("row1_found", row_out, 4'b1101);
        keys[5] = 1'b1;
        repeat (8) @(negedge clk);
        keys[5] = 1'b0;
        prev_row = row_out;
        for (int k = 0; k < 5; k++) begin
            cnt = 0;
            while (row_out == prev_row && cnt < 50) begin @(negedge clk); cnt++; end
            check("row_rot", row_out, {prev_row[2:0], prev_row[3]});
            prev_row = row_out;
        end
        wait_scans(10);
        check("glitch_drain", kq.size(), 0);

        // Long hold of 9: one strobe only.
        model_key(4'h9);
        keys[idx_of(4'h9)] = 1'b1;
        wait_scans(200);
        keys[idx_of(4'h9)] = 1'b0;
        wait_scans(40);
        check("hold9_drain", kq.size(), 0);
        press(4'h9);

        // 7 and 8 together in one row: ignored until 8 is released.
        keys[idx_of(4'h7)] = 1'b1;
        keys[idx_of(4'h8)] = 1'b1;
        wait_scans(40);
        keys[idx_of(4'h8)] = 1'b0;
        model_key(4'h7);
        wait_scans(40);
        keys[idx_of(4'h7)] = 1'b0;
        wait_scans(40);
        check("dual_drain", kq.size(), 0);
        press(4'hF);

        // Reset while key 3 is held in PRESSED; it must be accepted again.
        model_key(4'h3);
        keys[idx_of(4'h3)] = 1'b1;
        wait_scans(20);
        check("k3_drain", kq.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        m_tens  = 0;
        m_units = 0;
        model_key(4'h3);
        wait_scans(40);
        check("k3_again", kq.size(), 0);
        check("k3_value_hold", value_out, 0);
        keys[idx_of(4'h3)] = 1'b0;
        wait_scans(40);
        press(4'hF);

        wait_scans(5);
        check("val_drain", vq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
